// File: rtl/sr_cmd_gen_if.sv
// sr_cmd_gen_if
// Groups the button inputs and SR command outputs of sr_cmd_gen into one bundle.
//   set_btn, reset_btn : raw, possibly bouncing request levels (driven by master)
//   s, r               : one-shot set / reset command pulses (driven by slave)
//   busy               : a pulse or gap cycle is in progress
//   conflict           : one-cycle flag for colliding set/reset requests
//   cmd_cnt            : saturating count of issued commands
// The slave modport is the command generator; the master modport is whatever
// drives the buttons and consumes the commands.
interface sr_cmd_gen_if;
  logic       set_btn;
  logic       reset_btn;
  logic       s;
  logic       r;
  logic       busy;
  logic       conflict;
  logic [7:0] cmd_cnt;

  modport master (
    output set_btn,
    output reset_btn,
    input  s,
    input  r,
    input  busy,
    input  conflict,
    input  cmd_cnt
  );

  modport slave (
    input  set_btn,
    input  reset_btn,
    output s,
    output r,
    output busy,
    output conflict,
    output cmd_cnt
  );
endinterface

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen
// Turns two asynchronous, bouncing push-button levels into clean, mutually
// exclusive set/reset command pulses for a downstream SR flip-flop stage.
// Each button is synchronized, debounced and edge-detected into a one-cycle
// request; a small FSM issues PULSE_LEN-cycle s/r pulses separated by a gap
// cycle, remembers one request that arrives while busy, and flags collisions.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : sr_cmd_gen_if.slave (set_btn, reset_btn in; s, r, busy, conflict,
//          cmd_cnt out)
// Parameters:
//   DEB_CYCLES : stable synchronized samples needed to flip a debounced level (2..255)
//   PULSE_LEN  : width of each s/r pulse in clk cycles (1..15)
module sr_cmd_gen #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned PULSE_LEN  = 1
) (
  input logic          clk,
  input logic          rst,
  sr_cmd_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SET_P,
    RST_P,
    GAP
  } state_t;

  localparam logic [7:0] DEB_LAST   = 8'(DEB_CYCLES - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);

  // Index 0 is the set button, index 1 the reset button.
  logic [1:0] btn;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] deb;
  logic [1:0] deb_d;
  logic [1:0] req;
  logic [7:0] deb_cnt [2];

  logic       set_req;
  logic       rst_req;
  logic       collision;

  state_t     state;
  logic [3:0] pulse_cnt;
  logic       pend_set;
  logic       pend_rst;
  logic       s_q;
  logic       r_q;
  logic       busy_q;
  logic       conflict_q;
  logic [7:0] cmd_cnt_q;
  logic [7:0] cmd_cnt_next;

  assign btn       = {bus.reset_btn, bus.set_btn};
  assign set_req   = req[0];
  assign rst_req   = req[1];
  assign collision = set_req & rst_req;

  assign cmd_cnt_next = (cmd_cnt_q == 8'hFF) ? cmd_cnt_q : cmd_cnt_q + 8'd1;

  // Input conditioning: synchronizer, debounce counter, rising-edge request.
  // The request is registered off a delayed copy of the debounced level so a
  // new level reaches the FSM DEB_CYCLES+2 edges after it is first sampled,
  // putting the first pulse cycle at DEB_CYCLES+3.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      req   <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_d <= deb;
      req   <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Command FSM with registered outputs. A request seen while not idle is
  // held in a one-deep pending slot (latest type wins); colliding requests
  // are dropped, wipe the pending slot and only raise the conflict flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pulse_cnt  <= '0;
      pend_set   <= 1'b0;
      pend_rst   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      cmd_cnt_q  <= '0;
    end else begin
      conflict_q <= collision;

      if (collision) begin
        pend_set <= 1'b0;
        pend_rst <= 1'b0;
      end else if (state != IDLE) begin
        if (set_req) begin
          pend_set <= 1'b1;
          pend_rst <= 1'b0;
        end else if (rst_req) begin
          pend_rst <= 1'b1;
          pend_set <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          // A fresh request outranks a stale pending one of the other type.
          if (!collision) begin
            if (set_req || (pend_set && !rst_req)) begin
              state     <= SET_P;
              s_q       <= 1'b1;
              busy_q    <= 1'b1;
              pulse_cnt <= '0;
              pend_set  <= 1'b0;
              pend_rst  <= 1'b0;
              cmd_cnt_q <= cmd_cnt_next;
            end else if (rst_req || pend_rst) begin
              state     <= RST_P;
              r_q       <= 1'b1;
              busy_q    <= 1'b1;
              pulse_cnt <= '0;
              pend_set  <= 1'b0;
              pend_rst  <= 1'b0;
              cmd_cnt_q <= cmd_cnt_next;
            end
          end
        end

        SET_P, RST_P: begin
          if (pulse_cnt == PULSE_LAST) begin
            state <= GAP;
            s_q   <= 1'b0;
            r_q   <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt + 4'd1;
          end
        end

        GAP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          s_q    <= 1'b0;
          r_q    <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.busy     = busy_q;
  assign bus.conflict = conflict_q;
  assign bus.cmd_cnt  = cmd_cnt_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen
// Drives two sr_cmd_gen instances (PULSE_LEN 1 and 3, DEB_CYCLES 4) with the
// same button waveforms. Expected pulses and conflict flags are queued when
// stimulus is applied and checked by a negedge monitor as the DUTs produce them.
module tb_sr_cmd_gen;

  localparam int DEB = 4;
  localparam int PLA = 1;
  localparam int PLB = 3;
  // From the negedge where a level is driven to the negedge where the first
  // command cycle is visible: DEB+3 edges after the first sampling edge.
  localparam int LAT = DEB + 4;

  typedef struct {
    bit is_set;
    int start;
    int len;
  } pulse_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  int checks = 0;
  int errors = 0;

  pulse_t exp_a [$];
  pulse_t exp_b [$];
  int     conf_a [$];
  int     conf_b [$];

  bit in_pulse     [2];
  bit pulse_is_set [2];
  int pulse_start  [2];

  sr_cmd_gen_if if_a ();
  sr_cmd_gen_if if_b ();

  sr_cmd_gen #(.DEB_CYCLES(DEB), .PULSE_LEN(PLA)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  sr_cmd_gen #(.DEB_CYCLES(DEB), .PULSE_LEN(PLB)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic monitorOne(input int k, input logic s_v, input logic r_v,
                            input logic busy_v, input logic conf_v);
    string  nm;
    pulse_t p;
    bit     have;
    int     c;
    nm = (k == 0) ? "a" : "b";
    checkOutput({"sr_excl_", nm}, int'(s_v & r_v), 0);
    if (s_v | r_v) checkOutput({"busy_in_pulse_", nm}, int'(busy_v), 1);

    if (!in_pulse[k] && (s_v | r_v)) begin
      in_pulse[k]     = 1'b1;
      pulse_is_set[k] = s_v;
      pulse_start[k]  = cyc;
    end else if (in_pulse[k] && !(pulse_is_set[k] ? s_v : r_v)) begin
      in_pulse[k] = 1'b0;
      have = 1'b0;
      if (k == 0 && exp_a.size() > 0) begin
        p = exp_a.pop_front();
        have = 1'b1;
      end else if (k == 1 && exp_b.size() > 0) begin
        p = exp_b.pop_front();
        have = 1'b1;
      end
      if (!have) begin
        checkOutput({"unexpected_pulse_", nm}, 1, 0);
      end else begin
        checkOutput({"pulse_type_", nm}, int'(pulse_is_set[k]), int'(p.is_set));
        checkOutput({"pulse_start_", nm}, pulse_start[k], p.start);
        checkOutput({"pulse_len_", nm}, cyc - pulse_start[k], p.len);
      end
      if (s_v | r_v) begin
        in_pulse[k]     = 1'b1;
        pulse_is_set[k] = s_v;
        pulse_start[k]  = cyc;
      end
    end

    if (conf_v) begin
      have = 1'b0;
      c = 0;
      if (k == 0 && conf_a.size() > 0) begin
        c = conf_a.pop_front();
        have = 1'b1;
      end else if (k == 1 && conf_b.size() > 0) begin
        c = conf_b.pop_front();
        have = 1'b1;
      end
      if (!have) checkOutput({"unexpected_conflict_", nm}, 1, 0);
      else       checkOutput({"conflict_cycle_", nm}, cyc, c);
    end
  endtask

  always @(negedge clk) begin
    monitorOne(0, if_a.s, if_a.r, if_a.busy, if_a.conflict);
    monitorOne(1, if_b.s, if_b.r, if_b.busy, if_b.conflict);
  end

  task automatic setButtons(input logic set_lvl, input logic reset_lvl);
    if_a.set_btn   = set_lvl;
    if_a.reset_btn = reset_lvl;
    if_b.set_btn   = set_lvl;
    if_b.reset_btn = reset_lvl;
  endtask

  task automatic applyStimulus(input logic set_lvl, input logic reset_lvl);
    @(negedge clk);
    setButtons(set_lvl, reset_lvl);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    setButtons(1'b0, 1'b0);
    waitCycles(2);
    rst = 1'b0;
  endtask

  task automatic expectPulse(input bit is_set, input int start_a, input int start_b,
                             input int len_a, input int len_b);
    pulse_t p;
    p.is_set = is_set;
    p.start  = start_a;
    p.len    = len_a;
    exp_a.push_back(p);
    p.start  = start_b;
    p.len    = len_b;
    exp_b.push_back(p);
  endtask

  task automatic checkIdle(input string tag, input int cnt_exp);
    checkOutput({tag, "_s_a"}, int'(if_a.s), 0);
    checkOutput({tag, "_r_a"}, int'(if_a.r), 0);
    checkOutput({tag, "_busy_a"}, int'(if_a.busy), 0);
    checkOutput({tag, "_conflict_a"}, int'(if_a.conflict), 0);
    checkOutput({tag, "_cnt_a"}, int'(if_a.cmd_cnt), cnt_exp);
    checkOutput({tag, "_s_b"}, int'(if_b.s), 0);
    checkOutput({tag, "_r_b"}, int'(if_b.r), 0);
    checkOutput({tag, "_busy_b"}, int'(if_b.busy), 0);
    checkOutput({tag, "_conflict_b"}, int'(if_b.conflict), 0);
    checkOutput({tag, "_cnt_b"}, int'(if_b.cmd_cnt), cnt_exp);
  endtask

  initial begin
    int n;
    bit is_set;

    rst = 1'b1;
    setButtons(1'b0, 1'b0);
    waitCycles(2);
    rst = 1'b0;
    $display("[TB] reset state");
    checkIdle("reset", 0);

    // Single set press held high.
    $display("[TB] single set press");
    applyStimulus(1'b1, 1'b0);
    n = cyc;
    expectPulse(1'b1, n + LAT, n + LAT, PLA, PLB);
    waitCycles(LAT + PLB + 4);
    checkIdle("single_set", 1);
    applyStimulus(1'b0, 1'b0);
    waitCycles(15);
    checkIdle("single_set_release", 1);

    // Bouncing set button: level changes every 2 cycles, never stable long enough.
    $display("[TB] bouncing set button");
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2) == 0, 1'b0);
      waitCycles(1);
    end
    applyStimulus(1'b0, 1'b0);
    waitCycles(20);
    checkIdle("bounce", 0);

    // Both buttons rise together.
    $display("[TB] simultaneous set and reset");
    doReset();
    applyStimulus(1'b1, 1'b1);
    n = cyc;
    conf_a.push_back(n + LAT);
    conf_b.push_back(n + LAT);
    waitCycles(20);
    checkIdle("collide", 0);
    applyStimulus(1'b0, 1'b0);
    waitCycles(15);
    checkIdle("collide_release", 0);

    // Reset button rises 2 cycles after set: served from the pending slot
    // after the gap cycle and one idle cycle.
    $display("[TB] set then reset, pending service");
    doReset();
    applyStimulus(1'b1, 1'b0);
    n = cyc;
    waitCycles(1);
    applyStimulus(1'b1, 1'b1);
    expectPulse(1'b1, n + LAT, n + LAT, PLA, PLB);
    expectPulse(1'b0, n + LAT + PLA + 2, n + LAT + PLB + 2, PLA, PLB);
    waitCycles(30);
    checkIdle("set_then_reset", 2);
    applyStimulus(1'b0, 1'b0);
    waitCycles(15);

    // Reset in the second cycle of the pulse; the button is dropped at the same time.
    $display("[TB] reset mid-pulse");
    doReset();
    applyStimulus(1'b1, 1'b0);
    n = cyc;
    expectPulse(1'b1, n + LAT, n + LAT, PLA, 2);
    waitCycles(LAT + 1);
    rst = 1'b1;
    setButtons(1'b0, 1'b0);
    waitCycles(1);
    checkIdle("mid_pulse_rst", 0);
    rst = 1'b0;
    waitCycles(30);
    checkIdle("post_rst_quiet", 0);

    // Set button already high when reset is released.
    $display("[TB] button held through reset");
    rst = 1'b1;
    setButtons(1'b1, 1'b0);
    waitCycles(3);
    rst = 1'b0;
    n = cyc;
    expectPulse(1'b1, n + LAT, n + LAT, PLA, PLB);
    waitCycles(20);
    checkIdle("held_through_rst", 1);
    applyStimulus(1'b0, 1'b0);
    waitCycles(15);

    // 300 alternating presses: the counter must stop at 255.
    $display("[TB] alternating presses to saturation");
    doReset();
    for (int i = 0; i < 300; i++) begin
      is_set = ((i % 2) == 0);
      applyStimulus(is_set, !is_set);
      n = cyc;
      expectPulse(is_set, n + LAT, n + LAT, PLA, PLB);
      waitCycles(9);
      applyStimulus(1'b0, 1'b0);
      waitCycles(9);
    end
    waitCycles(10);
    checkIdle("saturate", 255);

    checkOutput("leftover_pulses_a", exp_a.size(), 0);
    checkOutput("leftover_pulses_b", exp_b.size(), 0);
    checkOutput("leftover_conflicts_a", conf_a.size(), 0);
    checkOutput("leftover_conflicts_b", conf_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
